// File: rtl/display_pkg.sv
// display_pkg: definitions shared by the accumulator display top and its
// binary-to-BCD converter.
//   - SEG_TABLE / SEG_BLANK : active-low {g..a} patterns for digits 0-9 and blank
//   - state_t               : double-dabble FSM states
//   - digits_for()          : decimal digits needed to show any width-bit value
package display_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Entry n holds the pattern for digit n.
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'b0010000,   // 9
      7'b0000000,   // 8
      7'b1111000,   // 7
      7'b0000010,   // 6
      7'b0010010,   // 5
      7'b0011001,   // 4
      7'b0110000,   // 3
      7'b0100100,   // 2
      7'b1111001,   // 1
      7'b1000000    // 0
   };

   // Smallest d with 10^d >= 2^width.
   function automatic int digits_for(input int width);
      longint unsigned lim;
      longint unsigned p;
      int              d;
      lim = (width >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << width);
      p   = 64'd1;
      d   = 0;
      for (int i = 0; i < 20; i++) begin
         if (p < lim) begin
            p = p * 64'd10;
            d = d + 1;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one bit per cycle.
// Ports:
//   clock, resetn : rising-edge clock, asynchronous active-low reset
//   start         : (re)start a conversion of value; aborts any conversion in flight
//   value         : WIDTH-bit binary input, captured when start is seen
//   busy          : high while in SHIFT or DONE
//   done          : one-cycle pulse on the edge that updates bcd
//   bcd           : DIGITS BCD digits, digit 0 in the LSBs
module bin2bcd_seq
   import display_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [WIDTH-1:0]      value,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t              state;
   logic [WIDTH-1:0]    shift;
   logic [4*DIGITS-1:0] scratch;
   logic [4*DIGITS-1:0] scratch_adj;
   logic [CW-1:0]       count;

   // Add-3 correction applied to every nibble before each shift.
   always_comb begin
      scratch_adj = scratch;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch[4*i +: 4] >= 4'd5)
            scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         shift   <= '0;
         scratch <= '0;
         count   <= '0;
         done    <= 1'b0;
         bcd     <= '0;
      end else begin
         done <= 1'b0;
         // start wins in every state, so an aborted conversion never reaches bcd.
         if (start) begin
            state   <= SHIFT;
            shift   <= value;
            scratch <= '0;
            count   <= '0;
         end else begin
            case (state)
               IDLE: ;
               SHIFT: begin
                  {scratch, shift} <= {scratch_adj, shift} << 1;
                  count            <= count + 1'b1;
                  if (count == CW'(WIDTH - 1))
                     state <= DONE;
               end
               DONE: begin
                  bcd   <= scratch;
                  done  <= 1'b1;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: rtl/accum_bcd_display.sv
// accum_bcd_display: add/subtract accumulator whose value is converted to
// decimal and shown on active-low 7-segment digits.
// Ports:
//   clock, resetn : rising-edge clock, asynchronous active-low reset
//   load, mode    : accumulate strobe (per high cycle); mode 0 = add, 1 = subtract
//   clear         : synchronous clear, wins over load
//   data_in       : operand
//   acc, carry    : accumulator and carry/borrow of the last operation
//   busy, done    : conversion in progress / one-cycle display-update pulse
//   bcd, hex      : decimal digits and segment patterns, digit 0 in the LSBs
module accum_bcd_display
   import display_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 3,
   parameter int BLANK_LZ = 0
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  load,
   input  logic                  mode,
   input  logic                  clear,
   input  logic [WIDTH-1:0]      data_in,
   output logic [WIDTH-1:0]      acc,
   output logic                  carry,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7*DIGITS-1:0]   hex
);

   generate
      if (WIDTH < 2) begin : g_width_check
         $error("accum_bcd_display: WIDTH must be at least 2");
      end
      if (DIGITS < digits_for(WIDTH)) begin : g_digits_check
         $error("accum_bcd_display: DIGITS too small to show every WIDTH-bit value");
      end
   endgenerate

   logic             start;
   logic [WIDTH:0]   sum;

   assign sum = {1'b0, acc} + {1'b0, data_in};

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         acc   <= '0;
         carry <= 1'b0;
         start <= 1'b0;
      end else begin
         // Every acting edge restarts the converter on the value it just produced.
         start <= load | clear;
         if (clear) begin
            acc   <= '0;
            carry <= 1'b0;
         end else if (load) begin
            if (!mode) begin
               {carry, acc} <= sum;
            end else begin
               acc   <= acc - data_in;
               carry <= (data_in > acc);
            end
         end
      end
   end

   bin2bcd_seq #(
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS)
   ) u_bin2bcd (
      .clock  (clock),
      .resetn (resetn),
      .start  (start),
      .value  (acc),
      .busy   (busy),
      .done   (done),
      .bcd    (bcd)
   );

   // hex is a pure decode of the registered bcd, so it changes on exactly the
   // edge that bcd does and its reset value follows from bcd = 0.
   // Scanning from the top digit down tracks whether everything above is zero.
   always_comb begin
      logic [3:0] digit;
      logic       all_zero;
      hex      = '0;
      digit    = '0;
      all_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         digit    = bcd[4*i +: 4];
         all_zero = all_zero && (digit == 4'd0);
         if ((BLANK_LZ != 0) && (i > 0) && all_zero)
            hex[7*i +: 7] = SEG_BLANK;
         else if (digit > 4'd9)
            hex[7*i +: 7] = SEG_BLANK;
         else
            hex[7*i +: 7] = SEG_TABLE[digit];
      end
   end

endmodule

// File: tb/tb_accum_bcd_display.sv
module tb_accum_bcd_display;

   logic        clock;
   logic        resetn;
   logic        load;
   logic        mode;
   logic        clear;
   logic [7:0]  data_in;
   logic [7:0]  acc0, acc1;
   logic        carry0, carry1;
   logic        busy0, busy1;
   logic        done0, done1;
   logic [11:0] bcd0, bcd1;
   logic [20:0] hex0, hex1;

   int checks   = 0;
   int passes   = 0;
   int done_cnt = 0;

   typedef struct {
      logic       ld;
      logic       md;
      logic       cl;
      logic [7:0] d;
      logic [7:0] exp_acc;
      logic       exp_carry;
      logic [11:0] exp_bcd;
   } vec_t;

   vec_t vecs[13];

   accum_bcd_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(0)) dut0 (
      .clock(clock), .resetn(resetn), .load(load), .mode(mode), .clear(clear),
      .data_in(data_in), .acc(acc0), .carry(carry0), .busy(busy0), .done(done0),
      .bcd(bcd0), .hex(hex0)
   );

   accum_bcd_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1)) dut1 (
      .clock(clock), .resetn(resetn), .load(load), .mode(mode), .clear(clear),
      .data_in(data_in), .acc(acc1), .carry(carry1), .busy(busy1), .done(done1),
      .bcd(bcd1), .hex(hex1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (done0) done_cnt <= done_cnt + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] seg_ref(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [20:0] hex_ref(input logic [11:0] b, input bit blank);
      logic [20:0] h;
      logic [3:0]  d;
      bit          lead;
      h    = '0;
      lead = 1'b1;
      for (int i = 2; i >= 0; i--) begin
         d = b[4*i +: 4];
         if (d != 4'd0) lead = 1'b0;
         h[7*i +: 7] = (blank && lead && i > 0) ? 7'b1111111 : seg_ref(d);
      end
      return h;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp)
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else
         passes++;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic op(input logic l, input logic m, input logic c, input logic [7:0] d);
      load = l; mode = m; clear = c; data_in = d;
      step();
      load = 1'b0; clear = 1'b0;
   endtask

   // Count edges until done is seen; returns 99 if it never arrives.
   task automatic wait_done(output int lat);
      lat = 99;
      for (int n = 1; n <= 30; n++) begin
         step();
         if (done0) begin
            lat = n;
            break;
         end
      end
   endtask

   initial begin
      int          lat;
      int          base;
      logic [20:0] exp_h;

      resetn = 1'b0; load = 1'b0; mode = 1'b0; clear = 1'b0; data_in = '0;

      //             ld    md    cl    d       acc     c     bcd
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'd200, 8'd200, 1'b0, 12'h200};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'd100, 8'd44,  1'b1, 12'h044};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'd0,   8'd0,   1'b0, 12'h000};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'd5,   8'd5,   1'b0, 12'h005};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'd7,   8'd254, 1'b1, 12'h254};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'd4,   8'd250, 1'b0, 12'h250};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'd6,   8'd0,   1'b1, 12'h000};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'd255, 8'd255, 1'b0, 12'h255};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'd255, 8'd0,   1'b0, 12'h000};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'd1,   8'd255, 1'b1, 12'h255};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 8'd1,   8'd0,   1'b1, 12'h000};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 8'd99,  8'd99,  1'b0, 12'h099};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 8'd89,  8'd10,  1'b0, 12'h010};

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      chk("reset acc", acc0, 0);
      chk("reset carry", carry0, 0);
      chk("reset busy", busy0, 0);
      chk("reset done", done0, 0);
      chk("reset bcd", bcd0, 0);
      chk("reset hex", hex0, {7'b1000000, 7'b1000000, 7'b1000000});
      chk("reset hex blank", hex1, {7'b1111111, 7'b1111111, 7'b1000000});
      resetn = 1'b1;
      step();

      // Table-driven operations, each followed by a full conversion
      for (int r = 0; r < 13; r++) begin
         base = done_cnt;
         op(vecs[r].ld, vecs[r].md, vecs[r].cl, vecs[r].d);
         chk($sformatf("row%0d acc", r), acc0, vecs[r].exp_acc);
         chk($sformatf("row%0d carry", r), carry0, vecs[r].exp_carry);
         wait_done(lat);
         chk($sformatf("row%0d latency", r), lat, 10);
         chk($sformatf("row%0d bcd", r), bcd0, vecs[r].exp_bcd);
         chk($sformatf("row%0d bcd blank", r), bcd1, vecs[r].exp_bcd);
         chk($sformatf("row%0d hex", r), hex0, hex_ref(vecs[r].exp_bcd, 1'b0));
         chk($sformatf("row%0d hex blank", r), hex1, hex_ref(vecs[r].exp_bcd, 1'b1));
         step();
         chk($sformatf("row%0d done pulse", r), done0, 0);
         chk($sformatf("row%0d busy after", r), busy0, 0);
         chk($sformatf("row%0d done count", r), done_cnt, base + 1);
      end

      // Restart: add 1 four cycles into a conversion of 9
      op(1'b0, 1'b0, 1'b1, 8'd0);
      wait_done(lat);
      step();
      base = done_cnt;
      op(1'b1, 1'b0, 1'b0, 8'd9);
      repeat (4) step();
      chk("restart busy mid", busy0, 1);
      op(1'b1, 1'b0, 1'b0, 8'd1);
      chk("restart acc", acc0, 10);
      wait_done(lat);
      chk("restart latency", lat, 10);
      chk("restart bcd", bcd0, 12'h010);
      repeat (12) step();
      chk("restart done count", done_cnt, base + 1);

      // Back-to-back loads: three high cycles, display follows the last
      base = done_cnt;
      load = 1'b1; mode = 1'b0; data_in = 8'd1;
      repeat (3) step();
      load = 1'b0;
      chk("b2b acc", acc0, 13);
      wait_done(lat);
      chk("b2b latency", lat, 10);
      chk("b2b bcd", bcd0, 12'h013);
      step();
      chk("b2b done count", done_cnt, base + 1);

      // Clear wins over load; carry is cleared too
      op(1'b1, 1'b0, 1'b0, 8'd250);
      chk("pre-clear carry", carry0, 1);
      wait_done(lat);
      op(1'b1, 1'b0, 1'b1, 8'd50);
      chk("clear acc", acc0, 0);
      chk("clear carry", carry0, 0);
      wait_done(lat);
      chk("clear bcd", bcd1, 12'h000);
      exp_h = {7'b1111111, 7'b1111111, 7'b1000000};
      chk("clear hex blank", hex1, exp_h);

      // Reset in the middle of a conversion
      op(1'b1, 1'b0, 1'b0, 8'd100);
      wait_done(lat);
      chk("pre-reset bcd", bcd0, 12'h100);
      op(1'b1, 1'b0, 1'b0, 8'd7);
      repeat (3) step();
      resetn = 1'b0;
      #2;
      chk("midrst acc", acc0, 0);
      chk("midrst busy", busy0, 0);
      chk("midrst bcd", bcd0, 0);
      chk("midrst hex", hex0, {7'b1000000, 7'b1000000, 7'b1000000});
      repeat (2) step();
      resetn = 1'b1;
      base = done_cnt;
      repeat (15) step();
      chk("midrst no done", done_cnt, base);
      chk("midrst busy after", busy0, 0);
      chk("midrst bcd after", bcd0, 0);
      chk("midrst acc after", acc0, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
